// File: rtl/mini_alu_exec_if.sv
// Instruction handshake between the fetch/IP logic and the mini-ALU execute stage.
// Packed instruction layout is {opcode, dst, src1, src0}.
interface mini_alu_exec_if #(
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 8
) ();
  logic                      iInstValid;
  logic                      oInstReady;
  logic [OPC_W+3*ADDR_W-1:0] iInstruction;

  modport master (output iInstValid, output iInstruction, input oInstReady);
  modport slave  (input iInstValid, input iInstruction, output oInstReady);
endinterface

// File: rtl/mini_alu_exec.sv
// Mini-ALU execute stage: register file, single-cycle ALU/branch ops, and an
// iterative shift-add multiplier writing the RL/RH result registers.
//
// state | meaning
// IDLE  | accepting instructions (unless a branch pulse is out)
// MUL   | one shift-add step per cycle, counter runs down to terminal count 1
module mini_alu_exec #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int REG_DEPTH = 16,
  parameter int OPC_W     = 4,
  parameter int LED_W     = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  mini_alu_exec_if.slave    inst,
  output logic              oBranchTaken,
  output logic [ADDR_W-1:0] oBranchTarget,
  output logic              oBusy,
  output logic [DATA_W-1:0] oRL,
  output logic [DATA_W-1:0] oRH,
  output logic [2:0]        oFlags,
  output logic [LED_W-1:0]  oLed
);

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(REG_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_RH = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_RL = {{(ADDR_W-1){1'b1}}, 1'b0};

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SMUL = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_UMUL = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BLE  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_LED  = OPC_W'(8);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                state;
  logic [DATA_W-1:0]     regFile [REG_DEPTH];
  logic [OPC_W-1:0]      opc;
  logic [ADDR_W-1:0]     dst, src1, src0;
  logic [DATA_W-1:0]     op1, op0, addRes, subRes, imm, magA, magB;
  logic                  addV, subV, bleTaken, dstOk, accept, isSigned;
  logic [2*DATA_W-1:0]   acc, mcand, accNext, prod;
  logic [DATA_W-1:0]     mplier;
  logic                  mulNeg;
  logic [CNT_W-1:0]      cnt;

  assign {opc, dst, src1, src0} = inst.iInstruction;
  assign inst.oInstReady = (state == IDLE) && !oBranchTaken;
  assign oBusy           = (state == MUL);
  assign accept          = inst.iInstValid && inst.oInstReady;

  // RH/RL alias the top two addresses; anything else past the file reads 0
  always_comb begin
    op1 = '0;
    op0 = '0;
    if (src1 == ADDR_RH)                  op1 = oRH;
    else if (src1 == ADDR_RL)             op1 = oRL;
    else if ({1'b0, src1} < DEPTH_L)      op1 = regFile[src1[IDX_W-1:0]];
    if (src0 == ADDR_RH)                  op0 = oRH;
    else if (src0 == ADDR_RL)             op0 = oRL;
    else if ({1'b0, src0} < DEPTH_L)      op0 = regFile[src0[IDX_W-1:0]];
  end

  always_comb begin
    addRes   = op1 + op0;
    subRes   = op1 - op0;
    addV     = (op1[MSB] == op0[MSB]) && (addRes[MSB] != op1[MSB]);
    subV     = (op1[MSB] != op0[MSB]) && (subRes[MSB] != op1[MSB]);
    bleTaken = $signed(op1) <= $signed(op0);
    imm      = DATA_W'({src1, src0});
    dstOk    = {1'b0, dst} < DEPTH_L;
    isSigned = (opc == OP_SMUL);
    magA     = (isSigned && op1[MSB]) ? -op1 : op1;
    magB     = (isSigned && op0[MSB]) ? -op0 : op0;
    accNext  = acc + (mplier[0] ? mcand : '0);
    prod     = mulNeg ? -accNext : accNext;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      for (int i = 0; i < REG_DEPTH; i++) regFile[i] <= '0;
      oRL           <= '0;
      oRH           <= '0;
      oFlags        <= '0;
      oLed          <= '0;
      oBranchTaken  <= 1'b0;
      oBranchTarget <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      mulNeg        <= 1'b0;
      cnt           <= '0;
    end else begin
      oBranchTaken <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (opc)
              OP_ADD: begin
                if (dstOk) regFile[dst[IDX_W-1:0]] <= addRes;
                oFlags <= {addV, addRes[MSB], addRes == '0};
              end
              OP_SUB: begin
                if (dstOk) regFile[dst[IDX_W-1:0]] <= subRes;
                oFlags <= {subV, subRes[MSB], subRes == '0};
              end
              OP_SMUL, OP_UMUL: begin
                acc    <= '0;
                mcand  <= {{DATA_W{1'b0}}, magA};
                mplier <= magB;
                mulNeg <= isSigned && (op1[MSB] ^ op0[MSB]);
                cnt    <= CNT_W'(DATA_W);
                state  <= MUL;
              end
              OP_STO: if (dstOk) regFile[dst[IDX_W-1:0]] <= imm;
              OP_BLE: begin
                if (bleTaken) begin
                  oBranchTaken  <= 1'b1;
                  oBranchTarget <= dst;
                end
              end
              OP_JMP: begin
                oBranchTaken  <= 1'b1;
                oBranchTarget <= dst;
              end
              OP_LED: oLed <= op1[LED_W-1:0];
              default: ;
            endcase
          end
        end
        MUL: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // last step folds straight into the result registers
          if (cnt == CNT_W'(1)) begin
            {oRH, oRL} <= prod;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_exec.sv
// Directed self-checking bench for mini_alu_exec with hand-computed results.
module tb_mini_alu_exec;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SMUL = 4'd3;
  localparam logic [3:0] OP_UMUL = 4'd4;
  localparam logic [3:0] OP_STO  = 4'd5;
  localparam logic [3:0] OP_BLE  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_LED  = 4'd8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        oBranchTaken;
  logic [7:0]  oBranchTarget;
  logic        oBusy;
  logic [15:0] oRL, oRH;
  logic [2:0]  oFlags;
  logic [7:0]  oLed;
  int          assertions = 0;
  int          failures   = 0;

  always #5 Clock = ~Clock;

  mini_alu_exec_if #(.OPC_W(4), .ADDR_W(8)) instIf ();

  mini_alu_exec #(
    .DATA_W(16), .ADDR_W(8), .REG_DEPTH(16), .OPC_W(4), .LED_W(8)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .inst          (instIf),
    .oBranchTaken  (oBranchTaken),
    .oBranchTarget (oBranchTarget),
    .oBusy         (oBusy),
    .oRL           (oRL),
    .oRH           (oRH),
    .oFlags        (oFlags),
    .oLed          (oLed)
  );

  task automatic issue(input logic [3:0] opc, input logic [7:0] dst,
                       input logic [7:0] s1, input logic [7:0] s0);
    int waitCycles;
    waitCycles = 0;
    @(negedge Clock);
    instIf.iInstruction = {opc, dst, s1, s0};
    instIf.iInstValid   = 1'b1;
    while (!instIf.oInstReady && waitCycles < 100) begin
      @(negedge Clock);
      waitCycles++;
    end
    if (!instIf.oInstReady) begin
      assertions++; failures++;
      $display("FAIL issue_timeout: opcode %0d never accepted", opc);
      instIf.iInstValid = 1'b0;
    end else begin
      @(posedge Clock); #1;
      instIf.iInstValid = 1'b0;
    end
  endtask

  task automatic sto(input logic [7:0] dst, input logic [15:0] val);
    issue(OP_STO, dst, val[15:8], val[7:0]);
  endtask

  task automatic waitMulDone(output int lowCycles);
    lowCycles = 0;
    while (!instIf.oInstReady && lowCycles < 40) begin
      lowCycles++;
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset();
    instIf.iInstValid   = 1'b0;
    instIf.iInstruction = '0;
    #2 Reset = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;
    assertions++; if (instIf.oInstReady !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", instIf.oInstReady); end
    assertions++; if (oBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    assertions++; if ({oRH, oRL} !== 32'h0) begin failures++; $display("FAIL reset_rlrh: got %h want 0", {oRH, oRL}); end
    assertions++; if ({oFlags, oLed} !== 11'h0) begin failures++; $display("FAIL reset_flags_led: got %h/%h want 0/0", oFlags, oLed); end
    assertions++; if ({oBranchTaken, oBranchTarget} !== 9'h0) begin failures++; $display("FAIL reset_branch: got %b/%h want 0/00", oBranchTaken, oBranchTarget); end
  endtask

  task automatic test_arith();
    sto(8'd1, 16'h0005);
    sto(8'd2, 16'h0007);
    issue(OP_ADD, 8'd3, 8'd2, 8'd1);
    assertions++; if (oFlags !== 3'b000) begin failures++; $display("FAIL add_flags: got %b want 000", oFlags); end
    issue(OP_LED, 8'd0, 8'd3, 8'd0);
    assertions++; if (oLed !== 8'h0C) begin failures++; $display("FAIL add_led: got %h want 0c", oLed); end
  endtask

  task automatic test_multiply();
    int n;
    sto(8'd5, 16'hFFFD);
    sto(8'd6, 16'h0007);
    issue(OP_SMUL, 8'd0, 8'd5, 8'd6);
    assertions++; if (oBusy !== 1'b1) begin failures++; $display("FAIL smul_busy: got %b want 1", oBusy); end
    waitMulDone(n);
    assertions++; if (n != 16) begin failures++; $display("FAIL smul_ready_low: got %0d cycles want 16", n); end
    assertions++; if ({oRH, oRL} !== 32'hFFFF_FFEB) begin failures++; $display("FAIL smul_result: got %h want ffffffeb", {oRH, oRL}); end
    assertions++; if (oBusy !== 1'b0) begin failures++; $display("FAIL smul_busy_end: got %b want 0", oBusy); end
    sto(8'd7, 16'hFFFF);
    issue(OP_UMUL, 8'd0, 8'd7, 8'd7);
    waitMulDone(n);
    assertions++; if ({oRH, oRL} !== 32'hFFFE_0001) begin failures++; $display("FAIL umul_result: got %h want fffe0001", {oRH, oRL}); end
    issue(OP_ADD, 8'd4, 8'd1, 8'hFE);
    issue(OP_LED, 8'd0, 8'd4, 8'd0);
    assertions++; if (oLed !== 8'h06) begin failures++; $display("FAIL add_rl_alias: got %h want 06", oLed); end
  endtask

  task automatic test_branch();
    sto(8'd2, 16'h0003);
    issue(OP_BLE, 8'h20, 8'd2, 8'd1);
    assertions++; if ({oBranchTaken, oBranchTarget} !== 9'h120) begin failures++; $display("FAIL ble_taken: got %b/%h want 1/20", oBranchTaken, oBranchTarget); end
    assertions++; if (instIf.oInstReady !== 1'b0) begin failures++; $display("FAIL ble_ready_drop: got %b want 0", instIf.oInstReady); end
    @(posedge Clock); #1;
    assertions++; if ({oBranchTaken, instIf.oInstReady} !== 2'b01) begin failures++; $display("FAIL ble_pulse_end: got %b want 01", {oBranchTaken, instIf.oInstReady}); end
    issue(OP_BLE, 8'h40, 8'd1, 8'd2);
    assertions++; if ({oBranchTaken, instIf.oInstReady} !== 2'b01) begin failures++; $display("FAIL ble_not_taken: got %b want 01", {oBranchTaken, instIf.oInstReady}); end
    issue(OP_JMP, 8'h33, 8'd0, 8'd0);
    assertions++; if ({oBranchTaken, oBranchTarget} !== 9'h133) begin failures++; $display("FAIL jmp: got %b/%h want 1/33", oBranchTaken, oBranchTarget); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] flagsBefore;
    sto(8'd8, 16'h00AA);
    issue(OP_LED, 8'd0, 8'd8, 8'd0);
    assertions++; if (oLed !== 8'hAA) begin failures++; $display("FAIL b2b_led: got %h want aa", oLed); end
    issue(OP_SUB, 8'd9, 8'd8, 8'd8);
    flagsBefore = oFlags;
    assertions++; if (flagsBefore !== 3'b001) begin failures++; $display("FAIL sub_zero_flags: got %b want 001", flagsBefore); end
    issue(4'd9, 8'd3, 8'd2, 8'd1);
    assertions++; if ({oLed, oFlags, oBranchTaken} !== {8'hAA, 3'b001, 1'b0}) begin failures++; $display("FAIL undefined_opcode: got %h/%b/%b want aa/001/0", oLed, oFlags, oBranchTaken); end
    issue(OP_LED, 8'd0, 8'h80, 8'd0);
    assertions++; if (oLed !== 8'h00) begin failures++; $display("FAIL out_of_range_read: got %h want 00", oLed); end
  endtask

  task automatic test_reset_during_mul();
    issue(OP_SMUL, 8'd0, 8'd5, 8'd6);
    repeat (4) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    assertions++; if (oBusy !== 1'b0) begin failures++; $display("FAIL mul_reset_busy: got %b want 0", oBusy); end
    assertions++; if ({oRH, oRL} !== 32'h0) begin failures++; $display("FAIL mul_reset_rlrh: got %h want 0", {oRH, oRL}); end
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;
    assertions++; if ({instIf.oInstReady, oBusy, oRL} !== {2'b10, 16'h0}) begin failures++; $display("FAIL mul_reset_release: got %b/%b/%h want 1/0/0000", instIf.oInstReady, oBusy, oRL); end
  endtask

  task automatic test_sub_flags();
    int n;
    sto(8'd1, 16'h8000);
    sto(8'd2, 16'h0001);
    issue(OP_SUB, 8'd3, 8'd1, 8'd2);
    assertions++; if (oFlags !== 3'b100) begin failures++; $display("FAIL sub_overflow_flags: got %b want 100", oFlags); end
    issue(OP_LED, 8'd0, 8'd3, 8'd0);
    assertions++; if (oLed !== 8'hFF) begin failures++; $display("FAIL sub_result: got %h want ff", oLed); end
    sto(8'd10, 16'h7FFF);
    issue(OP_ADD, 8'd11, 8'd10, 8'd2);
    assertions++; if (oFlags !== 3'b110) begin failures++; $display("FAIL add_overflow_flags: got %b want 110", oFlags); end
    issue(OP_SMUL, 8'd0, 8'd1, 8'd1);
    waitMulDone(n);
    assertions++; if ({oRH, oRL} !== 32'h4000_0000) begin failures++; $display("FAIL smul_most_negative: got %h want 40000000", {oRH, oRL}); end
    sto(8'd7, 16'h0003);
    issue(OP_UMUL, 8'd0, 8'd7, 8'd7);
    waitMulDone(n);
    sto(8'hFE, 16'h1234);
    assertions++; if (oRL !== 16'h0009) begin failures++; $display("FAIL sto_rl_dropped: got %h want 0009", oRL); end
    issue(OP_LED, 8'd0, 8'hFE, 8'd0);
    assertions++; if (oLed !== 8'h09) begin failures++; $display("FAIL led_rl_alias: got %h want 09", oLed); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_multiply();
    test_branch();
    test_back_to_back();
    test_reset_during_mul();
    test_sub_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/mini_alu_exec.md
Name: mini_alu_exec

Overview:
Parametrised execute stage for the mini-ALU processor. It accepts packed instructions over a valid/ready handshake and holds an internal register file. It executes single-cycle ADD/SUB/STO/LED/branch operations and multi-cycle iterative signed or unsigned multiplies into the RL/RH result registers. Branch decisions go back to the fetch/IP logic, which sits upstream beside the instruction ROM.

Parameters:
DATA_W, 16, datapath width; multiply product is 2*DATA_W split into RL/RH
ADDR_W, 8, width of each address/destination field
REG_DEPTH, 16, register-file entries (REG_DEPTH <= 2**ADDR_W - 2)
OPC_W, 4, opcode field width
LED_W, 8, LED register width (LED_W <= DATA_W)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
iInstValid  in  1  iInstruction valid
oInstReady  out  1  stage can accept; transfer on iInstValid && oInstReady at rising edge
iInstruction  in  OPC_W+3*ADDR_W  {opcode, dst, src1, src0}
oBranchTaken  out  1  registered one-cycle pulse: upstream must load IP with oBranchTarget
oBranchTarget  out  ADDR_W  branch destination (dst field of branch)
oBusy  out  1  multiply in progress
oRL  out  DATA_W  product low half
oRH  out  DATA_W  product high half
oFlags  out  3  {V,N,Z} from last ADD/SUB
oLed  out  LED_W  LED register

Behaviour:
- Reset (Reset=0, async): register file, oRL, oRH, oFlags, oLed, oBranchTaken, oBranchTarget all 0; FSM to IDLE; oBusy=0. A multiply in progress is aborted. oInstReady=1 from the first cycle after release.
- Opcodes:
  - NOP=0.
  - ADD=1: dst=src1+src0.
  - SUB=2: dst=src1-src0.
  - SMUL=3: {RH,RL}=src1*src0, signed.
  - UMUL=4: {RH,RL}=src1*src0, unsigned.
  - STO=5: dst=immediate.
  - BLE=6: branch if src1<=src0, signed compare.
  - JMP=7: unconditional branch.
  - LED=8: oLed<=src1 data[LED_W-1:0].
  - Codes 9..2**OPC_W-1 behave as NOP (no write, no LED update, no branch).
- Operand read, combinational at acceptance:
  - Address 2**ADDR_W-1 reads oRH.
  - Address 2**ADDR_W-2 reads oRL.
  - Address < REG_DEPTH reads the register.
  - Any other address reads 0.
- Immediate: {src1,src0} field bits, truncated or zero-extended to DATA_W.
- Writes: on the acceptance edge. An instruction accepted in the next cycle sees the new value; no hazard stall. Writes with dst >= REG_DEPTH (including the RL/RH aliases) are dropped.
- ADD/SUB:
  - Result truncated to DATA_W.
  - Z=(result==0), N=result MSB, V=signed overflow.
  - Flags update on the same edge as the write; no other op changes flags.
- Branch (BLE taken or JMP):
  - oBranchTaken=1 and oBranchTarget=dst for exactly the cycle after acceptance.
  - oInstReady=0 in that cycle, so the wrong-path instruction is not consumed.
  - A BLE that is not taken produces no pulse and no ready drop.
- FSM IDLE/MUL:
  - In IDLE, accepting SMUL/UMUL latches operand magnitudes, sign and mode, loads a counter with DATA_W, and moves to MUL.
  - MUL performs one shift-add step per cycle; oBusy=1 and oInstReady=0 throughout.
  - On the DATA_W-th MUL cycle edge: apply sign correction (SMUL), write oRL/oRH, return to IDLE.
  - Net effect: ready is low for exactly DATA_W cycles; the next accepted instruction reads the new RL/RH.
  - RL/RH hold their values between multiplies.
- Boundaries:
  - SMUL with most-negative operands (0x8000*0x8000) gives 0x40000000.
  - iInstValid is ignored while oInstReady=0; upstream holds the instruction.
  - Reset during MUL leaves RL/RH=0.

Test Plan:
- Hold Reset=0 for 3 cycles, then release -> all outputs 0, oInstReady=1 on the next cycle, oBusy=0.
- STO r1=0x0005, STO r2=0x0007, ADD r3=r2+r1, LED src1=r3 -> r3=0x000C, oLed=0x0C one cycle after the LED acceptance, oFlags=000.
- SMUL src1=0xFFFD (-3), src0=0x0007 -> oInstReady low exactly 16 cycles, oRL=0xFFEB, oRH=0xFFFF. Then UMUL 0xFFFF*0xFFFF -> oRL=0x0001, oRH=0xFFFE. Then ADD r4=RL+r1 (src0 addr 0xFE) -> r4=0x0006.
- r1=5, r2=3, BLE dst=0x20 src1=r2 src0=r1 -> oBranchTaken pulse of 1 cycle, oBranchTarget=0x20, oInstReady=0 that cycle. With src1=r1, src0=r2 -> no pulse.
- Start SMUL, assert Reset in MUL cycle 5 -> oBusy=0 immediately, oRL=oRH=0, FSM IDLE, ready=1 after release.
- STO r1=0x8000, STO r2=0x0001, SUB r3=r1-r2 -> r3=0x7FFF, oFlags V=1, N=0, Z=0. Then STO to dst=0xFE -> oRL unchanged.
